qsys_serial_requester: RTL and testbench

//  Processor-side end of the Qsys serial link; the upstream driver for the serial-to-Avalon host bridge.
//  - Accepts one parallel bus command (read/write, address, data) on a valid/ready port.
//  - Serialises it as a 65-bit frame and waits for the bridge's 32-bit serial reply.
//  - Returns the reply on a one-cycle response strobe. Timeouts and short replies are flagged as errors.

---
 rtl/qsys_serial_requester.sv | 264 ++++++++++++++++++++++++++
 tb/tb_qsys_serial_requester.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qsys_serial_requester.sv
// ---------------------------------------------------------------------------
// qsys_serial_requester
//
// Processor-side end of the Qsys serial link. A single parallel bus command
// (read/write, address, data) is taken on a valid/ready port and sent to the
// serial-to-Avalon host bridge as a 65-bit frame, MSB first:
//   bit 64 = write flag, bits 63..32 = address, bits 31..0 = write data
//   (reads send an all-zero data field).
// The block then waits for the bridge's 32-bit serial reply, MSB first, and
// returns it on a one-cycle response strobe. A reply that never starts, or
// one that stops before 32 bits, produces an error response with zero data.
//
// Every output is registered. The serial side (sle/sdo) trails the state
// register by one cycle: for a command accepted at edge 0, sle is high after
// edges 1..65 and low again after edge 66.
//
// Parameters
//   TIMEOUT_CYCLES  WAIT_RSP cycles allowed before an error response (>= 2)
//   TO_W            timeout counter width; must be able to hold TIMEOUT_CYCLES
//
// Ports
//   clk            in   1   block clock, also the serial link clock
//   reset          in   1   asynchronous reset, active-high
//   cmd_valid      in   1   command present
//   cmd_ready      out  1   command can be accepted (IDLE only)
//   cmd_write      in   1   1 = write, 0 = read
//   cmd_address    in   32  bus address
//   cmd_writedata  in   32  write data (ignored for reads)
//   rsp_valid      out  1   one-cycle response strobe
//   rsp_readdata   out  32  reply word, 0 on error
//   rsp_error      out  1   timeout or short reply, qualified by rsp_valid
//   sle            out  1   frame enable to the bridge
//   sdo            out  1   serial data to the bridge
//   sdi            in   1   serial data from the bridge
//   srdy           in   1   bridge reply-valid
//
// Optional feature (macro QSYS_SERIAL_REQ_STATS_EN)
//   Adds stat_xfers[15:0] (good responses) and stat_errors[15:0] (error
//   responses). Both reset to 0, count on the rsp_valid cycle and saturate
//   at 16'hFFFF. Without the macro these ports and counters do not exist.
// ---------------------------------------------------------------------------
module qsys_serial_requester #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_address,
  input  logic [31:0] cmd_writedata,
  output logic        rsp_valid,
  output logic [31:0] rsp_readdata,
  output logic        rsp_error,
  output logic        sle,
  output logic        sdo,
  input  logic        sdi,
  input  logic        srdy
`ifdef QSYS_SERIAL_REQ_STATS_EN
  ,
  output logic [15:0] stat_xfers,
  output logic [15:0] stat_errors
`endif
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SHIFT    = 3'd1,
    S_GAP      = 3'd2,
    S_WAIT_RSP = 3'd3,
    S_CAPTURE  = 3'd4,
    S_DONE     = 3'd5,
    S_ERR      = 3'd6,
    S_DRAIN    = 3'd7
  } state_t;

  // Last WAIT_RSP count before giving up: N cycles means counts 0..N-1.
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_SAT   = {TO_W{1'b1}};
  localparam logic [6:0]      BIT_SAT  = 7'h7F;
  localparam logic [6:0]      FRAME_LAST = 7'd64;
  localparam logic [6:0]      REPLY_LAST = 7'd31;

  // Saturating increment for the 16-bit statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      sat_inc16 = value;
    end else begin
      sat_inc16 = value + 16'd1;
    end
  endfunction

  state_t            state;
  state_t            next_state;
  logic [64:0]       frame;
  logic [6:0]        bit_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [31:0]       capture;
  logic [31:0]       capture_next;
  logic              accept;

  assign accept       = cmd_valid && cmd_ready;
  // Reply word with this cycle's sdi shifted in at the LSB.
  assign capture_next = {capture[30:0], sdi};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          next_state = S_SHIFT;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_SHIFT: begin
        // bit_cnt counts the frame bit being put out this cycle.
        if (bit_cnt == FRAME_LAST) begin
          next_state = S_GAP;
        end else begin
          next_state = S_SHIFT;
        end
      end
      S_GAP: begin
        next_state = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        // A reply starting on the last allowed cycle still wins.
        if (srdy) begin
          next_state = S_CAPTURE;
        end else if (to_cnt == TO_LAST) begin
          next_state = S_ERR;
        end else begin
          next_state = S_WAIT_RSP;
        end
      end
      S_CAPTURE: begin
        // bit_cnt holds the number of reply bits already taken.
        if (!srdy) begin
          next_state = S_ERR;
        end else if (bit_cnt == REPLY_LAST) begin
          next_state = S_DONE;
        end else begin
          next_state = S_CAPTURE;
        end
      end
      S_DONE: begin
        next_state = S_DRAIN;
      end
      S_ERR: begin
        next_state = S_DRAIN;
      end
      S_DRAIN: begin
        // Any srdy beyond the 32nd bit is swallowed here.
        if (!srdy) begin
          next_state = S_IDLE;
        end else begin
          next_state = S_DRAIN;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Frame shifter, bit counter, timeout counter and reply capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame   <= 65'd0;
      bit_cnt <= 7'd0;
      to_cnt  <= {TO_W{1'b0}};
      capture <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            frame   <= {cmd_write, cmd_address, (cmd_write ? cmd_writedata : 32'd0)};
            bit_cnt <= 7'd0;
          end
        end
        S_SHIFT: begin
          frame <= {frame[63:0], 1'b0};
          if (bit_cnt != BIT_SAT) begin
            bit_cnt <= bit_cnt + 7'd1;
          end
        end
        S_GAP: begin
          to_cnt  <= {TO_W{1'b0}};
          bit_cnt <= 7'd0;
        end
        S_WAIT_RSP: begin
          if (srdy) begin
            capture <= capture_next;
            bit_cnt <= 7'd1;
          end else if (to_cnt != TO_SAT) begin
            to_cnt <= to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
          end
        end
        S_CAPTURE: begin
          if (srdy) begin
            capture <= capture_next;
            if (bit_cnt != BIT_SAT) begin
              bit_cnt <= bit_cnt + 7'd1;
            end
          end
        end
        default: begin
          frame <= frame;
        end
      endcase
    end
  end

  // Registered outputs. Serial pins follow the current state (one cycle
  // behind it); the handshake and response follow the next state so that
  // rsp_valid coincides with the DONE/ERR state cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_ready    <= 1'b1;
      sle          <= 1'b0;
      sdo          <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_error    <= 1'b0;
      rsp_readdata <= 32'd0;
    end else begin
      cmd_ready    <= (next_state == S_IDLE);
      sle          <= (state == S_SHIFT);
      sdo          <= (state == S_SHIFT) ? frame[64] : 1'b0;
      rsp_valid    <= (next_state == S_DONE) || (next_state == S_ERR);
      rsp_error    <= (next_state == S_ERR);
      rsp_readdata <= (next_state == S_DONE) ? capture_next : 32'd0;
    end
  end

`ifdef QSYS_SERIAL_REQ_STATS_EN
  // Good/error response counters, stepped during the rsp_valid cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_xfers  <= 16'd0;
      stat_errors <= 16'd0;
    end else begin
      if (state == S_DONE) begin
        stat_xfers <= sat_inc16(stat_xfers);
      end
      if (state == S_ERR) begin
        stat_errors <= sat_inc16(stat_errors);
      end
    end
  end
`endif

endmodule

// File: tb/tb_qsys_serial_requester.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for qsys_serial_requester.
// The DUT is built with TIMEOUT_CYCLES=16. Inputs change 1 ns after a rising
// edge and outputs are sampled at the same point. The bench plays the bridge:
// it collects the 65 frame bits and drives srdy/sdi for the reply.
// ---------------------------------------------------------------------------
module tb_qsys_serial_requester;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_address = 32'd0;
  logic [31:0] cmd_writedata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_readdata;
  logic        rsp_error;
  logic        sle;
  logic        sdo;
  logic        sdi = 1'b0;
  logic        srdy = 1'b0;
`ifdef QSYS_SERIAL_REQ_STATS_EN
  logic [15:0] stat_xfers;
  logic [15:0] stat_errors;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int waited;
  int seen;

  always #5 clk = ~clk;

  qsys_serial_requester #(
    .TIMEOUT_CYCLES(16),
    .TO_W(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_address(cmd_address),
    .cmd_writedata(cmd_writedata),
    .rsp_valid(rsp_valid),
    .rsp_readdata(rsp_readdata),
    .rsp_error(rsp_error),
    .sle(sle),
    .sdo(sdo),
    .sdi(sdi),
    .srdy(srdy)
`ifdef QSYS_SERIAL_REQ_STATS_EN
    ,
    .stat_xfers(stat_xfers),
    .stat_errors(stat_errors)
`endif
  );

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one command and check the 65-bit frame it produces.
  task automatic send_frame(input string tag, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [64:0] exp_frame);
    logic [64:0] got;
    int          high_cnt;
    chk({tag, " ready"}, 65'(cmd_ready), 65'd1);
    cmd_valid = 1'b1; cmd_write = w; cmd_address = a; cmd_writedata = d;
    tick;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = 32'd0; cmd_writedata = 32'd0;
    chk({tag, " busy"}, 65'({cmd_ready, sle}), 65'd0);
    got = 65'd0;
    high_cnt = 0;
    for (int k = 0; k < 65; k++) begin
      tick;
      if (sle === 1'b1) high_cnt++;
      got[64-k] = sdo;
    end
    chk({tag, " sle_cycles"}, 65'(high_cnt), 65'd65);
    chk({tag, " frame"}, got, exp_frame);
    tick;
    chk({tag, " gap"}, 65'({sle, sdo}), 65'd0);
  endtask

  // Bridge reply: idle cycles, then nbits of word MSB first.
  task automatic reply(input logic [31:0] word, input int idle, input int nbits, input bit keep_high);
    for (int i = 0; i < idle; i++) tick;
    for (int i = 0; i < nbits; i++) begin
      srdy = 1'b1;
      sdi  = word[31-i];
      tick;
    end
    sdi = 1'b0;
    if (!keep_high) srdy = 1'b0;
  endtask

  task automatic wait_rsp(input int bound, output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < bound) begin
      tick;
      n++;
    end
  endtask

`ifdef QSYS_SERIAL_REQ_STATS_EN
  task automatic good_txn(input logic [31:0] word);
    int n;
    send_frame("stat_good", 1'b0, 32'h00000040, 32'd0, {1'b0, 32'h00000040, 32'h00000000});
    reply(word, 1, 32, 1'b0);
    wait_rsp(40, n);
    chk("stat_good rsp", 65'({rsp_valid, rsp_error, rsp_readdata}), 65'({1'b1, 1'b0, word}));
    tick; tick;
  endtask

  task automatic timeout_txn;
    int n;
    send_frame("stat_to", 1'b0, 32'h00000044, 32'd0, {1'b0, 32'h00000044, 32'h00000000});
    wait_rsp(40, n);
    chk("stat_to rsp", 65'({rsp_valid, rsp_error, rsp_readdata}), 65'({1'b1, 1'b1, 32'd0}));
    tick; tick;
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset outs", 65'({cmd_ready, sle, sdo, rsp_valid, rsp_error, rsp_readdata}),
        65'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0}));
    @(negedge clk);
    reset = 1'b0;
    tick;
    chk("after release ready", 65'(cmd_ready), 65'd1);

    // 1: write, full reply with minimum latency.
    send_frame("t1", 1'b1, 32'h00000010, 32'hDEADBEEF, {1'b1, 32'h00000010, 32'hDEADBEEF});
    reply(32'h12345678, 0, 32, 1'b0);
    wait_rsp(40, waited);
    chk("t1 latency", 65'(waited), 65'd0);
    chk("t1 rsp", 65'({rsp_valid, rsp_error, rsp_readdata}), 65'({1'b1, 1'b0, 32'h12345678}));
    chk("t1 ready_in_rsp", 65'(cmd_ready), 65'd0);
    tick;
    chk("t1 strobe_one", 65'({rsp_valid, cmd_ready}), 65'd0);
    tick;
    chk("t1 idle", 65'(cmd_ready), 65'd1);

    // 2: read, data ignored, reply after 7 idle cycles, srdy held past 32 bits.
    send_frame("t2", 1'b0, 32'h00000004, 32'hFFFFFFFF, {1'b0, 32'h00000004, 32'h00000000});
    reply(32'hCAFEF00D, 7, 32, 1'b1);
    wait_rsp(40, waited);
    chk("t2 latency", 65'(waited), 65'd0);
    chk("t2 rsp", 65'({rsp_valid, rsp_error, rsp_readdata}), 65'({1'b1, 1'b0, 32'hCAFEF00D}));
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) seen++;
    end
    chk("t2 drain_hold", 65'(seen), 65'd0);
    srdy = 1'b0;
    tick;
    chk("t2 idle", 65'(cmd_ready), 65'd1);

    // 3: timeout, srdy never asserted.
    send_frame("t3", 1'b0, 32'h00000100, 32'd0, {1'b0, 32'h00000100, 32'h00000000});
    wait_rsp(40, waited);
    chk("t3 timeout_cycles", 65'(waited), 65'd16);
    chk("t3 rsp", 65'({rsp_valid, rsp_error, rsp_readdata}), 65'({1'b1, 1'b1, 32'd0}));
    tick; tick;
    chk("t3 idle", 65'(cmd_ready), 65'd1);

    // 4: short reply of 20 bits.
    send_frame("t4", 1'b1, 32'h00000020, 32'h55AA33CC, {1'b1, 32'h00000020, 32'h55AA33CC});
    reply(32'hFFFFFFFF, 0, 20, 1'b0);
    wait_rsp(40, waited);
    chk("t4 latency", 65'(waited), 65'd1);
    chk("t4 rsp", 65'({rsp_valid, rsp_error, rsp_readdata}), 65'({1'b1, 1'b1, 32'd0}));
    tick; tick;
    chk("t4 idle", 65'(cmd_ready), 65'd1);

`ifdef QSYS_SERIAL_REQ_STATS_EN
    chk("stats before reset", 65'({stat_xfers, stat_errors}), 65'({16'd2, 16'd2}));
`endif

    // 5: reset in the middle of the frame.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 32'hABCD0000; cmd_writedata = 32'h0F0F0F0F;
    tick;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = 32'd0; cmd_writedata = 32'd0;
    repeat (31) tick;
    chk("t5 mid_frame sle", 65'(sle), 65'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5 async_clear", 65'({sle, sdo, rsp_valid}), 65'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (rsp_valid !== 1'b0 || sle !== 1'b0) seen++;
    end
    chk("t5 silent_abort", 65'(seen), 65'd0);
`ifdef QSYS_SERIAL_REQ_STATS_EN
    chk("stats reset", 65'({stat_xfers, stat_errors}), 65'd0);
`endif
    send_frame("t5b", 1'b0, 32'h00000007, 32'h12341234, {1'b0, 32'h00000007, 32'h00000000});
    reply(32'h0BADC0DE, 2, 32, 1'b0);
    wait_rsp(40, waited);
    chk("t5b rsp", 65'({rsp_valid, rsp_error, rsp_readdata}), 65'({1'b1, 1'b0, 32'h0BADC0DE}));
    tick; tick;
    chk("t5b idle", 65'(cmd_ready), 65'd1);

`ifdef QSYS_SERIAL_REQ_STATS_EN
    // 6: 3 good + 2 timeouts since the last reset, then reset clears.
    good_txn(32'h00000001);
    good_txn(32'h80000000);
    timeout_txn;
    timeout_txn;
    chk("t6 stats", 65'({stat_xfers, stat_errors}), 65'({16'd3, 16'd2}));
    reset = 1'b1;
    #1;
    chk("t6 stats_clear", 65'({stat_xfers, stat_errors}), 65'd0);
    @(negedge clk);
    reset = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
